// File: rtl/pattern_sequencer.sv
// pattern_sequencer: records WIDTH-bit patterns into a DEPTH-entry buffer and
// replays them to a registered output. Playback advances one entry per
// internal tick. It supports loop, one-shot, ping-pong and pause modes.
module pattern_sequencer #(
  parameter int WIDTH    = 2,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 12_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rec,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         pat_in,
  input  logic [1:0]               mode,
  input  logic                     run,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);

  localparam logic [1:0] MODE_LOOP     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_PAUSE    = 2'd3;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    last;
  logic [TW-1:0]    tick_cnt;
  dir_t             dir;
  logic             tick;
  logic             wr_en;
  logic             step;
  logic             single;

  assign full   = (count == COUNT_FULL);
  assign tick   = (tick_cnt == TICK_LAST);
  assign wr_en  = rec && !clr && !full;
  assign step   = tick && run && (count != '0) && (mode != MODE_PAUSE) && !done && !clr;
  assign last   = AW'(count - COUNT_ONE);
  assign single = (count == COUNT_ONE);

  // Buffer write at the append position plus a registered read of the playback entry
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[count[AW-1:0]] <= pat_in;
    end
    rd_data <= mem[rd_ptr];
  end

  // Free-running step divider; only reset restarts it, so clr and run leave the cadence alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Playback state machine: clear/record bookkeeping, then advance the read pointer by mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      out    <= '0;
      done   <= 1'b0;
      rd_ptr <= '0;
      dir    <= DIR_UP;
    end else if (clr) begin
      count  <= '0;
      out    <= '0;
      done   <= 1'b0;
      rd_ptr <= '0;
      dir    <= DIR_UP;
    end else begin
      if (wr_en) begin
        count <= count + COUNT_ONE;
      end
      if (!run) begin
        rd_ptr <= '0;
        dir    <= DIR_UP;
        done   <= 1'b0;
      end else if (step) begin
        out <= rd_data;
        case (mode)
          MODE_LOOP: begin
            if (rd_ptr == last) rd_ptr <= '0;
            else                rd_ptr <= rd_ptr + AW'(1);
          end
          MODE_ONESHOT: begin
            if (rd_ptr == last) done   <= 1'b1;
            else                rd_ptr <= rd_ptr + AW'(1);
          end
          MODE_PINGPONG: begin
            if (dir == DIR_UP) begin
              if (rd_ptr == last) begin
                dir    <= DIR_DOWN;
                rd_ptr <= single ? '0 : last - AW'(1);
              end else begin
                rd_ptr <= rd_ptr + AW'(1);
              end
            end else begin
              if (rd_ptr == '0) begin
                dir    <= DIR_UP;
                rd_ptr <= single ? '0 : AW'(1);
              end else begin
                rd_ptr <= rd_ptr - AW'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Parametrised record/playback sequencer: captures WIDTH-bit patterns into an on-chip DEPTH-entry buffer on each record pulse, then replays them to an output register at a rate set by an internal tick divider. Adds loop, one-shot, ping-pong and pause playback modes, a clear command, a full flag and a done flag to the two-LED button sequencer. Sits between the debounced button front end and the LED/output pins of the board-level top.

## Interface
- WIDTH, 2: pattern width in bits.
- DEPTH, 16: buffer entries; power of two, ≥2. AW = clog2(DEPTH).
- TICK_DIV, 12_000_000: clk cycles per playback step; ≥2.

- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- rec  in  1  one-cycle pulse (pre-debounced): append pat_in.
- clr  in  1  one-cycle pulse: empty buffer, stop playback.
- pat_in  in  WIDTH  pattern written on rec.
- mode  in  2  0 loop, 1 one-shot, 2 ping-pong, 3 pause.
- run  in  1  level; playback enable.
- out  out  WIDTH  current playback pattern (registered).
- count  out  AW+1  number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH (combinational from count).
- done  out  1  one-shot finished (registered).

## Operation
- Reset (rst_n=0 at edge): count=0, out=0, done=0, rd_ptr=0, dir=up, tick counter=0. Buffer contents undefined/not cleared.
- Record: rec && !clr && !full → mem[count] <= pat_in, count <= count+1. rec while full: ignored, no wrap, count stays DEPTH.
- Clear: clr → count=0, out=0, rd_ptr=0, dir=up, done=0. clr and rec same cycle: clr wins, rec dropped.
- Tick: free-running counter 0..TICK_DIV-1; tick=1 for the one cycle it equals TICK_DIV-1. Not reset by clr or run.
- Read: rd_data <= mem[rd_ptr] every cycle (synchronous read, 1-cycle latency).
- run=0: rd_ptr=0, dir=up, done=0 each cycle; out holds.
- Step condition: tick && run && count≠0 && mode≠3 && !done && !clr. On step: out <= rd_data, then rd_ptr advances by mode (L = count-1, using count before any same-cycle rec):
  - loop: rd_ptr==L → 0, else +1.
  - one-shot: rd_ptr==L → done=1, rd_ptr held; else +1. done holds out until run low, clr or reset.
  - ping-pong: up: rd_ptr==L → dir=down, rd_ptr = (count==1 ? 0 : L-1); else +1. down: rd_ptr==0 → dir=up, rd_ptr = (count==1 ? 0 : 1); else −1. Endpoints not repeated.
  - pause (3): rd_ptr, dir, out held.
- count=0 with run=1: no step, out holds.
- Recording during playback permitted; new entries join the sequence at next wrap/turn. rec address (count) never equals rd_ptr (rd_ptr < count), so no read/write collision.
- Mode change mid-playback: takes effect at next step; dir retained; done cleared only by run low/clr/reset.

## Timing
- out changes only on a step edge; value = entry at rd_ptr as held at least one cycle before (guaranteed by TICK_DIV≥2).
- First step after run rises outputs entry 0; steps are exactly TICK_DIV cycles apart.
- count/full update the edge after rec; done rises on the step edge that outputs entry L.
- Widths: count AW+1 bits (holds DEPTH); rd_ptr AW bits; all comparisons unsigned.

## Test plan (WIDTH=2, DEPTH=4, TICK_DIV=4)
- Reset then rec 1,2,3 → count=3, full=0; run=1, mode=0 → out 1,2,3,1,2 on successive ticks, 4 clk apart.
- rec 0,1,2,3 then rec 2 → count stays 4, full=1, mem unchanged; loop plays 0,1,2,3,0.
- mode=1 with entries 1,2,3 → out 1,2,3, done=1 at third step, out held 3; run low one cycle then high → done=0, replays 1.
- mode=2 with entries 0,1,2,3 → out 0,1,2,3,2,1,0,1; with single entry 2 → out 2 every tick.
- Playing loop, assert mode=3 for 3 ticks → out frozen; mode=0 → continues from next entry. Pulse clr and rec together → count=0, out=0, entry not stored.
- rst_n low mid-playback one cycle → out=0, count=0, done=0; no steps until new rec.
